// File: rtl/seq_pattern_detector_if.sv
// Bus bundle for seq_pattern_detector: run-time config, qualified serial stream, match results.
interface seq_pattern_detector_if #(
    parameter int unsigned LEN   = 4,
    parameter int unsigned CNT_W = 8
);
    logic             cfg_we;
    logic [LEN-1:0]   cfg_pattern;
    logic             cfg_overlap;
    logic             data_valid;
    logic             data_in;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             armed;

    modport master (
        output cfg_we, cfg_pattern, cfg_overlap, data_valid, data_in,
        input  match, match_count, armed
    );

    modport slave (
        input  cfg_we, cfg_pattern, cfg_overlap, data_valid, data_in,
        output match, match_count, armed
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// Programmable LEN-bit serial pattern recogniser with overlap mode and saturating match counter.
module seq_pattern_detector #(
    parameter int unsigned LEN   = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_pattern_detector_if.slave bus
);
    localparam int unsigned FILL_W = $clog2(LEN + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HUNT = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [LEN-1:0]     hist, hist_n;
    logic [LEN-1:0]     pattern, pattern_n;
    logic [LEN-1:0]     shift_c;
    logic [FILL_W-1:0]  fill, fill_n;
    logic [FILL_W-1:0]  fill_inc_c;
    logic               overlap, overlap_n;
    logic               match, match_n;
    logic               armed, armed_n;
    logic [CNT_W-1:0]   count, count_n;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            hist    <= '0;
            fill    <= '0;
            pattern <= '0;
            overlap <= 1'b0;
            match   <= 1'b0;
            armed   <= 1'b0;
            count   <= '0;
        end else begin
            state   <= state_n;
            hist    <= hist_n;
            fill    <= fill_n;
            pattern <= pattern_n;
            overlap <= overlap_n;
            match   <= match_n;
            armed   <= armed_n;
            count   <= count_n;
        end
    end

    // Next-state and next-output logic; cfg_we wins over a coincident sample
    always_comb begin
        state_n    = state;
        hist_n     = hist;
        fill_n     = fill;
        pattern_n  = pattern;
        overlap_n  = overlap;
        count_n    = count;
        match_n    = 1'b0;
        shift_c    = {hist[LEN-2:0], bus.data_in};
        fill_inc_c = (fill == FILL_W'(LEN)) ? fill : fill + FILL_W'(1);

        if (bus.cfg_we) begin
            pattern_n = bus.cfg_pattern;
            overlap_n = bus.cfg_overlap;
            hist_n    = '0;
            fill_n    = '0;
            count_n   = '0;
            state_n   = FILL;
        end else begin
            case (state)
                FILL, HUNT: begin
                    if (bus.data_valid) begin
                        hist_n  = shift_c;
                        fill_n  = fill_inc_c;
                        state_n = (fill_inc_c == FILL_W'(LEN)) ? HUNT : FILL;
                        if ((fill_inc_c == FILL_W'(LEN)) && (shift_c == pattern)) begin
                            match_n = 1'b1;
                            if (count != {CNT_W{1'b1}}) begin
                                count_n = count + CNT_W'(1);
                            end
                            // Non-overlapping: no bit of this match may seed the next one
                            if (!overlap) begin
                                hist_n  = '0;
                                fill_n  = '0;
                                state_n = FILL;
                            end
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        armed_n = (state_n != IDLE);
    end

    assign bus.match       = match;
    assign bus.match_count = count;
    assign bus.armed       = armed;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Bench for seq_pattern_detector: directed scenarios plus random traffic against a queue-based model.
module tb_seq_pattern_detector;
    localparam int unsigned LEN = 4;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    seq_pattern_detector_if #(.LEN(LEN), .CNT_W(8)) bus_a ();
    seq_pattern_detector_if #(.LEN(LEN), .CNT_W(2)) bus_b ();

    seq_pattern_detector #(.LEN(LEN), .CNT_W(8)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    seq_pattern_detector #(.LEN(LEN), .CNT_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: accepted bits since last clear, judged on the newest LEN of them
    logic [LEN-1:0] m_pat;
    logic           m_ovl;
    logic           m_armed;
    logic           m_match;
    int             m_cnt_a;
    int             m_cnt_b;
    bit             q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_pat   = '0;
        m_ovl   = 1'b0;
        m_armed = 1'b0;
        m_match = 1'b0;
        m_cnt_a = 0;
        m_cnt_b = 0;
        q.delete();
    endtask

    task automatic model_step(input logic we, input logic [LEN-1:0] pat, input logic ovl,
                              input logic v, input logic d);
        int w;
        m_match = 1'b0;
        if (!reset) begin
            model_clear();
        end else if (we) begin
            m_pat   = pat;
            m_ovl   = ovl;
            m_armed = 1'b1;
            m_cnt_a = 0;
            m_cnt_b = 0;
            q.delete();
        end else if (m_armed && v) begin
            q.push_back(d);
            if (q.size() > LEN) void'(q.pop_front());
            if (q.size() == LEN) begin
                w = 0;
                for (int i = 0; i < LEN; i++) w = (w << 1) | int'(q[i]);
                if (w == int'(m_pat)) begin
                    m_match = 1'b1;
                    if (m_cnt_a < 255) m_cnt_a++;
                    if (m_cnt_b < 3) m_cnt_b++;
                    if (!m_ovl) q.delete();
                end
            end
        end
    endtask

    task automatic check_all(input string ctx);
        chk({ctx, "_a_match"}, 32'(bus_a.match), 32'(m_match));
        chk({ctx, "_a_count"}, 32'(bus_a.match_count), 32'(m_cnt_a));
        chk({ctx, "_a_armed"}, 32'(bus_a.armed), 32'(m_armed));
        chk({ctx, "_b_match"}, 32'(bus_b.match), 32'(m_match));
        chk({ctx, "_b_count"}, 32'(bus_b.match_count), 32'(m_cnt_b));
        chk({ctx, "_b_armed"}, 32'(bus_b.armed), 32'(m_armed));
    endtask

    // One clock: drive, clock edge, update model, check #1 after the edge
    task automatic step(input string ctx, input logic we, input logic [LEN-1:0] pat,
                        input logic ovl, input logic v, input logic d);
        bus_a.cfg_we = we;  bus_a.cfg_pattern = pat;  bus_a.cfg_overlap = ovl;
        bus_a.data_valid = v;  bus_a.data_in = d;
        bus_b.cfg_we = we;  bus_b.cfg_pattern = pat;  bus_b.cfg_overlap = ovl;
        bus_b.data_valid = v;  bus_b.data_in = d;
        @(posedge clk);
        model_step(we, pat, ovl, v, d);
        #1;
        check_all(ctx);
    endtask

    task automatic feed(input string ctx, input logic [6:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(ctx, 1'b0, '0, 1'b0, 1'b1, bits[i]);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        model_clear();

        // Reset held, then released: random valid data without any config stays inert
        for (int i = 0; i < 3; i++) step("rst", 1'b0, '0, 1'b0, 1'b1, 1'($urandom));
        #2 reset = 1'b1;
        for (int i = 0; i < 10; i++) step("idle", 1'b0, '0, 1'b0, 1'b1, 1'($urandom));
        chk("idle_count", 32'(bus_a.match_count), 32'd0);

        // Overlap: 1011 over 1,0,1,1,0,1,1 -> matches after samples 4 and 7
        step("ovl_cfg", 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0);
        chk("ovl_armed", 32'(bus_a.armed), 32'd1);
        feed("ovl", 7'b1011011, 7);
        chk("ovl_last_match", 32'(bus_a.match), 32'd1);
        chk("ovl_count", 32'(bus_a.match_count), 32'd2);
        step("ovl_tail", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        chk("ovl_pulse_end", 32'(bus_a.match), 32'd0);

        // Non-overlap: same stream -> single match
        step("novl_cfg", 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
        feed("novl", 7'b1011011, 7);
        chk("novl_count", 32'(bus_a.match_count), 32'd1);

        // Gapped valid: idle cycles between every bit of 1011
        step("gap_cfg", 1'b1, 4'b1011, 1'b0, 1'b0, 1'b0);
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] gbits;
            gbits = 4'b1011;
            step("gap_bit", 1'b0, '0, 1'b0, 1'b1, gbits[i]);
            step("gap_idle", 1'b0, '0, 1'b0, 1'b0, 1'b1);
            step("gap_idle2", 1'b0, '0, 1'b0, 1'b0, 1'b0);
        end
        chk("gap_count", 32'(bus_a.match_count), 32'd1);

        // Saturation: 1111 overlapping on eight ones -> five matches, CNT_W=2 holds at 3
        step("sat_cfg", 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
        feed("sat", 7'b1111111, 7);
        step("sat", 1'b0, '0, 1'b0, 1'b1, 1'b1);
        chk("sat_a_count", 32'(bus_a.match_count), 32'd5);
        chk("sat_b_count", 32'(bus_b.match_count), 32'd3);

        // Collision: sample alongside cfg_we is dropped
        step("col_cfg", 1'b1, 4'b0110, 1'b0, 1'b1, 1'b0);
        chk("col_count", 32'(bus_a.match_count), 32'd0);
        feed("col", 7'b0000110, 3);
        chk("col_no_match", 32'(bus_a.match), 32'd0);
        feed("col2", 7'b0000110, 4);
        chk("col_late_match", 32'(bus_a.match), 32'd1);

        // Reset mid-run after two bits clears asynchronously
        step("mid_cfg", 1'b1, 4'b1010, 1'b1, 1'b0, 1'b0);
        feed("mid", 7'b0000010, 2);
        #2 reset = 1'b0;
        #1;
        model_clear();
        check_all("mid_async");
        step("mid_hold", 1'b0, '0, 1'b0, 1'b1, 1'b1);
        #2 reset = 1'b1;
        feed("mid_after", 7'b0001010, 4);
        chk("mid_after_armed", 32'(bus_a.armed), 32'd0);

        // Random traffic with occasional reconfiguration
        step("rnd_cfg", 1'b1, 4'($urandom), 1'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            step("rnd", ($urandom_range(0, 39) == 0), 4'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) != 0), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_pattern_detector.md
# seq_pattern_detector

Parametrised serial pattern detector: a Moore-style recogniser for a programmable LEN-bit sequence on a 1-bit qualified input stream. The pattern and overlap mode are loaded at run time, and every match is counted. It is the general replacement for fixed 4-state hand-coded sequence FSMs and sits between a serial bit source and control logic that consumes the match pulses and the count.

## Interface
- LEN, default 4: pattern length in bits; legal range 2..32.
- CNT_W, default 8: width of the saturating match counter; minimum 1.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset == 0 resets).
- cfg_we  input  1  when 1, loads cfg_pattern and cfg_overlap and re-arms the detector.
- cfg_pattern  input  LEN  pattern; bit LEN-1 is the first (oldest) bit expected, bit 0 is the last.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- data_valid  input  1  qualifies data_in; a sample is accepted on an edge where data_valid == 1.
- data_in  input  1  serial data bit.
- match  output  1  registered one-cycle pulse per detected pattern.
- match_count  output  CNT_W  number of matches since the last reset or cfg_we; saturates.
- armed  output  1  high once a pattern has been loaded (state != IDLE).

## Operation
- State register values: IDLE, FILL, HUNT. The default/illegal encoding decodes to IDLE.
- Internal registers:
  - hist[LEN-1:0]: history shift register; the newest bit is shifted into bit 0.
  - fill: count of valid history bits, 0..LEN.
  - pattern and overlap registers.
- IDLE: entered on reset. Samples are ignored. On cfg_we go to FILL.
- cfg_we, from any state:
  - pattern <= cfg_pattern, overlap <= cfg_overlap.
  - hist <= 0, fill <= 0, match_count <= 0, match <= 0.
  - Next state is FILL.
  - cfg_we has priority; a sample presented in the same cycle is dropped.
- Accepted sample (data_valid == 1, cfg_we == 0, state FILL or HUNT):
  - hist_n = {hist[LEN-2:0], data_in}.
  - fill_n = min(fill + 1, LEN).
- FILL: stays in FILL while fill_n < LEN; goes to HUNT when fill_n == LEN.
- Match condition: fill_n == LEN and hist_n == pattern, evaluated on an accepted sample.
- On a match:
  - match <= 1.
  - match_count increments; it holds at 2^CNT_W-1 once saturated and never wraps.
  - overlap == 1: hist <= hist_n, fill stays LEN, state stays HUNT.
  - overlap == 0: hist <= 0, fill <= 0, state goes to FILL. No match can use any bit of the previous match.
- On no match: match <= 0.
- Cycles with data_valid == 0:
  - hist, fill, state and match_count hold.
  - match <= 0, so the pulse is never stretched.
- Outputs are purely registered; there is no combinational path from inputs to outputs.

## Timing
- Reset values: match = 0, match_count = 0, armed = 0, state = IDLE, hist = 0, fill = 0, pattern = 0, overlap = 0.
- Reset asserted mid-stream clears everything immediately and asynchronously. A pattern must be reloaded afterwards.
- Latency: match is high in the cycle immediately after the edge that accepted the last pattern bit. match_count updates on that same edge.
- Back-to-back matches (overlap = 1, e.g. pattern 1111 with a stream of ones) give consecutive match cycles.
- armed rises the cycle after the cfg_we edge.
- Minimum spacing from cfg_we to first possible match: LEN accepted samples.
- A sample on the same edge as cfg_we is dropped and not counted.

## Test plan
- Reset/idle: hold reset = 0, then release. Drive data_valid = 1 with random data and no cfg_we -> match = 0, match_count = 0 and armed = 0 throughout.
- Overlap: LEN = 4, load 1011 with overlap = 1, feed 1,0,1,1,0,1,1 on consecutive cycles -> match pulses after sample 4 and sample 7; match_count = 2.
- Non-overlap: same pattern and stream with overlap = 0 -> single pulse after sample 4; match_count = 1.
- Gapped valid plus saturation:
  - Insert data_valid = 0 cycles between every bit of 1011 -> match still fires once, exactly one cycle after the last accepted bit.
  - With CNT_W = 2, 5 matches -> match_count stays 3.
- Collision and reset mid-run:
  - Assert cfg_we (pattern 0110) together with data_valid = 1 -> that sample is dropped, match_count = 0; matching 0110 needs 4 further samples.
  - Asserting reset after 2 bits -> armed = 0 immediately and no match.
